mlu_mul_ctrl: RTL and testbench

- Sequencer for the 16-lane multiplier layer of the MLU.
- Runs one job of N 16-element chunks per start command.
- Mode 0 (direct): issues paired hotBuff/coldBuff reads, drives sel_in=1 and tags each product beat valid/last toward the adder layer.
- Mode 1 (feedback): drives sel_in=0, so lanes square the adder-layer data; the block only gates, counts and terminates the beats arriving on pre_valid.

---
 rtl/mlu_mul_if.sv | 32 +++
 rtl/mlu_mul_ctrl.sv | 70 +++++++
 tb/tb_mlu_mul_ctrl.sv | 187 ++++++++++++++++++
 3 files changed

// File: rtl/mlu_mul_if.sv
// mlu_mul_if: job config, flow control, status and beat tags between the MLU multiplier sequencer and its host
// Signals: start/mode/num_chunks/hot_base/cold_base (job request), stall/pre_valid (flow), busy/done (status),
// hot_rd_*/cold_rd_* (buffer reads), sel_in/mul_valid/mul_last (multiplier layer control).
interface mlu_mul_if #(
  parameter int ADDR_W = 10,
  parameter int CNT_W  = 10
);
  logic              start;
  logic              mode;
  logic [CNT_W-1:0]  num_chunks;
  logic [ADDR_W-1:0] hot_base;
  logic [ADDR_W-1:0] cold_base;
  logic              stall;
  logic              pre_valid;
  logic              busy;
  logic              done;
  logic              hot_rd_en;
  logic [ADDR_W-1:0] hot_rd_addr;
  logic              cold_rd_en;
  logic [ADDR_W-1:0] cold_rd_addr;
  logic              sel_in;
  logic              mul_valid;
  logic              mul_last;
  modport master (
    output start, mode, num_chunks, hot_base, cold_base, stall, pre_valid,
    input  busy, done, hot_rd_en, hot_rd_addr, cold_rd_en, cold_rd_addr, sel_in, mul_valid, mul_last
  );
  modport slave (
    input  start, mode, num_chunks, hot_base, cold_base, stall, pre_valid,
    output busy, done, hot_rd_en, hot_rd_addr, cold_rd_en, cold_rd_addr, sel_in, mul_valid, mul_last
  );
endinterface

// File: rtl/mlu_mul_ctrl.sv
// mlu_mul_ctrl: sequencer for the 16-lane MLU multiplier layer; runs one job of N chunks per start
// Ports: clk (rising edge), rst_n (asynchronous, active low), bus (slave side of mlu_mul_if):
//   in : start, mode (0 direct, 1 feedback), num_chunks, hot_base, cold_base, stall, pre_valid
//   out: busy, done, hot/cold read strobes and addresses, sel_in, mul_valid, mul_last
module mlu_mul_ctrl #(
  parameter int ADDR_W = 10,
  parameter int CNT_W  = 10,
  parameter int RD_LAT = 1
) (
  input logic      clk,
  input logic      rst_n,
  mlu_mul_if.slave bus
);
  localparam logic [2:0] IDLE = 3'd0, ISSUE = 3'd1, DRAIN = 3'd2, FEED = 3'd3, FIN = 3'd4;
  logic [2:0]        state, nxt;
  logic [CNT_W-1:0]  n_q, last_idx, issue_cnt, retire_cnt;
  logic [ADDR_W-1:0] hot_q, cold_q;
  logic [RD_LAT-1:0] pipe, pipe_nxt;
  logic              sel_q, rd_en, accept, retire;
  assign accept   = state == IDLE && bus.start;
  assign last_idx = n_q - CNT_W'(1);
  assign rd_en    = state == ISSUE && !bus.stall;
  assign retire   = bus.mul_valid && !bus.stall;
  // The valid pipe mirrors the buffer read latency; it only moves when the buffers themselves advance.
  if (RD_LAT == 1) begin : g_pipe1
    assign pipe_nxt = rd_en;
  end else begin : g_pipen
    assign pipe_nxt = {pipe[RD_LAT-2:0], rd_en};
  end
  assign bus.busy         = state == ISSUE || state == DRAIN || state == FEED;
  assign bus.done         = state == FIN;
  assign bus.hot_rd_en    = rd_en;
  assign bus.cold_rd_en   = rd_en;
  assign bus.hot_rd_addr  = hot_q + ADDR_W'(issue_cnt);
  assign bus.cold_rd_addr = cold_q + ADDR_W'(issue_cnt);
  assign bus.sel_in       = sel_q;
  // Feedback beats come straight from the adder layer; outside FEED the pipe tail is the only source.
  assign bus.mul_valid    = state == FEED ? bus.pre_valid : pipe[RD_LAT-1];
  assign bus.mul_last     = bus.mul_valid && retire_cnt == last_idx;
  always_comb
    nxt = state == IDLE  ? (!bus.start ? IDLE : bus.num_chunks == '0 ? FIN : bus.mode ? FEED : ISSUE) :
          state == ISSUE ? (rd_en && issue_cnt == last_idx ? DRAIN : ISSUE) :
          (state == DRAIN || state == FEED) ? (retire && retire_cnt == last_idx ? FIN : state) :
          IDLE;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state      <= IDLE;
      n_q        <= '0;
      hot_q      <= '0;
      cold_q     <= '0;
      issue_cnt  <= '0;
      retire_cnt <= '0;
      pipe       <= '0;
      sel_q      <= 1'b1;
    end else begin
      state <= nxt;
      if (accept) begin
        n_q        <= bus.num_chunks;
        hot_q      <= bus.hot_base;
        cold_q     <= bus.cold_base;
        sel_q      <= !bus.mode;
        issue_cnt  <= '0;
        retire_cnt <= '0;
      end else begin
        if (rd_en) issue_cnt <= issue_cnt + CNT_W'(1);
        if (retire) retire_cnt <= retire_cnt + CNT_W'(1);
      end
      if (!bus.stall) pipe <= pipe_nxt;
    end
endmodule

// File: tb/tb_mlu_mul_ctrl.sv
// tb_mlu_mul_ctrl: scoreboard bench driving two sequencers (RD_LAT 1 and 2) with identical stimulus
module tb_mlu_mul_ctrl;
  localparam int AW   = 10;
  localparam int CW   = 10;
  localparam int MASK = (1 << AW) - 1;
  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0, mode = 1'b0, stall = 1'b0, pre_valid = 1'b0;
  logic [CW-1:0] num_chunks = '0;
  logic [AW-1:0] hot_base = '0, cold_base = '0;
  logic [1:0]    busy_s, done_s, hen_s, cen_s, sel_s, mv_s, ml_s;
  logic [AW-1:0] ha_s [2];
  logic [AW-1:0] ca_s [2];
  int tests = 0, fails = 0, cyc = 0, u = 0, start_cyc = -10;
  bit start_nz = 1'b0, job_mode = 1'b0;
  int last_ret_cyc [2] = '{0, 0};
  int done_cnt [2] = '{0, 0};
  int q_hot [2][$];
  int q_cold [2][$];
  int q_ret [2][$];
  int q_last [2][$];
  int q_done [2][$];

  always #5 clk = ~clk;

  for (genvar g = 0; g < 2; g++) begin : gl
    mlu_mul_if #(.ADDR_W(AW), .CNT_W(CW)) bus ();
    assign bus.start      = start;
    assign bus.mode       = mode;
    assign bus.num_chunks = num_chunks;
    assign bus.hot_base   = hot_base;
    assign bus.cold_base  = cold_base;
    assign bus.stall      = stall;
    assign bus.pre_valid  = pre_valid;
    assign busy_s[g] = bus.busy;
    assign done_s[g] = bus.done;
    assign hen_s[g]  = bus.hot_rd_en;
    assign cen_s[g]  = bus.cold_rd_en;
    assign sel_s[g]  = bus.sel_in;
    assign mv_s[g]   = bus.mul_valid;
    assign ml_s[g]   = bus.mul_last;
    assign ha_s[g]   = bus.hot_rd_addr;
    assign ca_s[g]   = bus.cold_rd_addr;
    mlu_mul_ctrl #(.ADDR_W(AW), .CNT_W(CW), .RD_LAT(g + 1)) dut (
      .clk(clk),
      .rst_n(rst_n),
      .bus(bus)
    );
  end

  task automatic chk(input string nm, input int d, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s dut%0d cyc %0d: got %0d, expected %0d", nm, d, cyc, act, exp);
    end
  endtask

  // Monitor: a beat read at unstalled-cycle index U must retire exactly at unstalled index U+RD_LAT.
  always @(negedge clk) begin
    int e;
    cyc++;
    if (!stall && rst_n) u++;
    for (int d = 0; d < 2; d++) begin
      if (!rst_n) begin
        chk("reset_outputs", d, {busy_s[d], done_s[d], hen_s[d], cen_s[d], mv_s[d], ml_s[d]}, 0);
        chk("reset_sel_in", d, sel_s[d], 1);
        chk("reset_addr", d, ha_s[d] | ca_s[d], 0);
      end else begin
        if (cyc == start_cyc) chk("busy_after_start", d, busy_s[d], start_nz);
        chk("cold_en_tracks_hot", d, cen_s[d], hen_s[d]);
        chk("last_needs_valid", d, ml_s[d] & ~mv_s[d], 0);
        if (stall) chk("no_read_in_stall", d, hen_s[d], 0);
        if (busy_s[d] | done_s[d]) chk("sel_in", d, sel_s[d], !job_mode);
        if (job_mode) chk("feed_valid", d, mv_s[d], pre_valid && q_last[d].size() > 0);
        if (hen_s[d]) begin
          chk("read_expected", d, q_hot[d].size() > 0, 1);
          if (q_hot[d].size() > 0) begin
            chk("hot_rd_addr", d, ha_s[d], q_hot[d].pop_front());
            chk("cold_rd_addr", d, ca_s[d], q_cold[d].pop_front());
            q_ret[d].push_back(u + d + 1);
          end
        end
        if (mv_s[d] && !stall) begin
          chk("beat_expected", d, q_last[d].size() > 0, 1);
          if (q_last[d].size() > 0) begin
            chk("mul_last", d, ml_s[d], q_last[d].pop_front());
            if (!job_mode) chk("beat_latency", d, u, q_ret[d].size() > 0 ? q_ret[d].pop_front() : -1);
            last_ret_cyc[d] = cyc;
          end
        end
        if (done_s[d]) begin
          done_cnt[d]++;
          chk("done_expected", d, q_done[d].size() > 0, 1);
          if (q_done[d].size() > 0) begin
            e = q_done[d].pop_front();
            chk("done_cycle", d, cyc, e < 0 ? last_ret_cyc[d] + 1 : e);
          end
          chk("busy_low_at_done", d, busy_s[d], 0);
          chk("job_drained", d, q_hot[d].size() + q_last[d].size() + q_ret[d].size(), 0);
        end
      end
    end
  end

  // Called just after the accepting edge: queue every read, beat and done the job must produce.
  task automatic expect_job(input bit m, input int n, input int hb, input int cb);
    job_mode  = m;
    start_nz  = n != 0;
    start_cyc = cyc + 1;
    for (int d = 0; d < 2; d++) begin
      for (int k = 0; k < n; k++) begin
        if (!m) begin
          q_hot[d].push_back((hb + k) & MASK);
          q_cold[d].push_back((cb + k) & MASK);
        end
        q_last[d].push_back(k == n - 1);
      end
      q_done[d].push_back(n == 0 ? cyc + 1 : -1);
    end
  endtask

  task automatic run_job(input bit m, input int n, input int hb, input int cb, input logic [31:0] smask,
                         input logic [31:0] pmask, input bit hold, input bit poke);
    int t0, t1;
    t0 = done_cnt[0] + 1;
    t1 = done_cnt[1] + 1;
    @(posedge clk); #1;
    mode = m; num_chunks = CW'(n); hot_base = AW'(hb); cold_base = AW'(cb);
    start = 1'b1; stall = 1'b0; pre_valid = 1'b0;
    @(posedge clk); #1;
    expect_job(m, n, hb, cb);
    for (int i = 1; done_cnt[0] < t0 || done_cnt[1] < t1; i++) begin
      if (i > 4000) begin
        $display("FAIL job_timeout: done not seen after %0d cycles (n=%0d)", i, n);
        $fatal(1, "job did not complete");
      end
      start      = (i == 1 && hold) || (i == 2 && poke);
      mode       = (i == 2 && poke) ? !m : m;
      num_chunks = (i == 2 && poke) ? CW'(n + 3) : CW'(n);
      stall      = i < 32 ? smask[i] : 1'b0;
      pre_valid  = i < 32 ? pmask[i] : 1'b1;
      @(posedge clk); #1;
    end
    start = 1'b0; stall = 1'b0; pre_valid = 1'b0;
  endtask

  task automatic reset_mid_job();
    @(posedge clk); #1;
    mode = 1'b0; num_chunks = CW'(8); hot_base = AW'('h100); cold_base = AW'('h200); start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    expect_job(1'b0, 8, 'h100, 'h200);
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    for (int d = 0; d < 2; d++) begin
      q_hot[d].delete(); q_cold[d].delete(); q_ret[d].delete(); q_last[d].delete(); q_done[d].delete();
    end
    rst_n = 1'b1;
  endtask

  initial begin
    int n;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    run_job(1'b0, 4, 'h10, 'h20, 32'h0, 32'h0, 1'b0, 1'b1);
    run_job(1'b0, 3, 'h40, 'h50, 32'h18, 32'h0, 1'b0, 1'b0);
    run_job(1'b0, 4, 'h3FE, 'h001, 32'h0, 32'h0, 1'b0, 1'b0);
    run_job(1'b1, 5, 0, 0, 32'h0, 32'h1DA, 1'b0, 1'b1);
    run_job(1'b0, 0, 'h7, 'h7, 32'h0, 32'hFFFF_FFFF, 1'b1, 1'b0);
    run_job(1'b1, 0, 'h7, 'h7, 32'h0, 32'hFFFF_FFFF, 1'b1, 1'b0);
    reset_mid_job();
    run_job(1'b0, 6, 'h123, 'h321, 32'h0, 32'h0, 1'b0, 1'b0);
    for (int j = 0; j < 40; j++) begin
      n = $urandom_range(0, 9);
      run_job(1'($urandom_range(0, 1)), n, $urandom_range(0, MASK), $urandom_range(0, MASK),
              $urandom & $urandom, $urandom, 1'($urandom_range(0, 1)), n > 0 && $urandom_range(0, 1) == 1);
    end
    run_job(1'b0, 1023, $urandom_range(0, MASK), $urandom_range(0, MASK), 32'h0, 32'h0, 1'b0, 1'b1);
    run_job(1'b1, 1023, 0, 0, 32'h0, 32'hFFFF_FFFF, 1'b0, 1'b0);
    repeat (3) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
